// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioner.
// Holds the per-channel FSM state encoding and the internal counter width.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_e;

  // One counter width serves both the debounce count and the repeat timer.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, counter debouncer, press/hold/repeat FSM
// and a wrapping press counter.
module btn_channel
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 3,
  parameter int CNT_W           = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             btn_raw_i,
  input  logic             repeat_en_i,
  output logic             level_o,
  output logic             press_pulse_o,
  output logic             release_pulse_o,
  output logic [CNT_W-1:0] press_count_o
);

  localparam int TW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic RAW_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [TW-1:0] DB_LAST = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RP_LAST = TW'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_pressed;
  logic                   acc_q, acc_d;
  logic [TW-1:0]          cnt_q, cnt_d;
  logic [TW-1:0]          tmr_q, tmr_d;
  btn_state_e             state_q, state_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic [CNT_W-1:0]       count_q, count_d;

  assign s_pressed = sync_q[SYNC_STAGES-1] ^ RAW_IDLE;

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = '0;
    state_d   = state_q;
    tmr_d     = tmr_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    if (s_pressed != acc_q) begin
      if (cnt_q == DB_LAST) acc_d = s_pressed;
      else                  cnt_d = cnt_q + 1'b1;
    end

    // FSM reacts to the accepted state of this same edge so pulses line up with level.
    case (state_q)
      IDLE: begin
        if (acc_d) begin
          state_d = HELD;
          tmr_d   = '0;
          press_d = 1'b1;
        end
      end
      HELD: begin
        if (!acc_d) begin
          state_d   = IDLE;
          tmr_d     = '0;
          release_d = 1'b1;
        end else if (!repeat_en_i) begin
          tmr_d = '0;
        end else if (tmr_q == RD_LAST) begin
          state_d = REPEAT;
          tmr_d   = '0;
          press_d = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!acc_d) begin
          state_d   = IDLE;
          tmr_d     = '0;
          release_d = 1'b1;
        end else if (!repeat_en_i) begin
          state_d = HELD;
          tmr_d   = '0;
        end else if (tmr_q == RP_LAST) begin
          tmr_d   = '0;
          press_d = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase

    count_d = count_q + CNT_W'(press_d);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q    <= {SYNC_STAGES{RAW_IDLE}};
      acc_q     <= 1'b0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      state_q   <= IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_raw_i};
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
    end
  end

  assign level_o         = acc_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;
  assign press_count_o   = count_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: one independent btn_channel per key,
// with per-channel press counters packed side by side.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 3,
  parameter int CNT_W           = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [N_BTN-1:0]       btn_raw,
  input  logic [N_BTN-1:0]       repeat_en,
  output logic [N_BTN-1:0]       level,
  output logic [N_BTN-1:0]       press_pulse,
  output logic [N_BTN-1:0]       release_pulse,
  output logic [N_BTN*CNT_W-1:0] press_count
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk_i          (Clk),
      .rst_i          (Reset),
      .btn_raw_i      (btn_raw[g]),
      .repeat_en_i    (repeat_en[g]),
      .level_o        (level[g]),
      .press_pulse_o  (press_pulse[g]),
      .release_pulse_o(release_pulse[g]),
      .press_count_o  (press_count[g*CNT_W +: CNT_W])
    );
  end

endmodule
